// File: rtl/drs_share_arbiter.sv
// drs_share_arbiter: time-shares one dynamic right shifter between N_REQ requesters.
// Build option: define DRS_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module drs_share_arbiter #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned RS        = 5,
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ID_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*WORD_SIZE-1:0]   req_a,
    input  logic [N_REQ*RS-1:0]          req_b,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [WORD_SIZE-1:0]         res_data,
    output logic [ID_W-1:0]              res_id
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t               state_q;
    logic [WORD_SIZE-1:0] op_a_q;
    logic [RS-1:0]        op_b_q;
    logic [ID_W-1:0]      op_id_q;
    logic [WORD_SIZE-1:0] res_data_q;
    logic [ID_W-1:0]      res_id_q;
    logic                 res_valid_q;

    logic                 any_valid;
    logic [ID_W-1:0]      grant_id;
    logic [WORD_SIZE-1:0] grant_a;
    logic [RS-1:0]        grant_b;
    logic [WORD_SIZE-1:0] drs_out;

    assign any_valid = |req_valid;

`ifdef DRS_ARB_RR_EN
    logic [ID_W-1:0] ptr_q;

    // Search starts at the pointer and wraps at N_REQ.
    always_comb begin
        logic          found;
        logic [ID_W:0] sum;
        logic [ID_W-1:0] idx;
        found    = 1'b0;
        grant_id = '0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end
    end
`else
    always_comb begin
        logic found;
        found    = 1'b0;
        grant_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[k]) begin
                found    = 1'b1;
                grant_id = ID_W'(k);
            end
        end
    end
`endif

    always_comb begin
        grant_a = '0;
        grant_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == grant_id) begin
                grant_a = req_a[k*WORD_SIZE +: WORD_SIZE];
                grant_b = req_b[k*RS +: RS];
            end
        end
    end

    // Gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == StIdle && any_valid) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Logarithmic barrel shifter, zero-filled.
    always_comb begin
        drs_out = op_a_q;
        for (int s = 0; s < RS; s++) begin
            if (op_b_q[s]) begin
                drs_out = drs_out >> (1 << s);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
`ifdef DRS_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        op_a_q  <= grant_a;
                        op_b_q  <= grant_b;
                        op_id_q <= grant_id;
                        state_q <= StShift;
`ifdef DRS_ARB_RR_EN
                        ptr_q   <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
`endif
                    end
                end
                StShift: begin
                    res_data_q  <= drs_out;
                    res_id_q    <= op_id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_drs_share_arbiter.sv
// tb_drs_share_arbiter: directed vectors plus a transaction-level model compared every cycle.
`timescale 1ns/1ps
module tb_drs_share_arbiter;
    localparam int W   = 32;
    localparam int RS  = 5;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*RS-1:0]  req_b;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic [IDW-1:0]   res_id;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    drs_share_arbiter #(.WORD_SIZE(W), .RS(RS), .N_REQ(N), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: one outstanding transaction, timed in cycles ----------------
    bit             m_busy = 1'b0;
    int             m_acc  = 0;
    int             m_cyc  = 0;
    int             m_ptr  = 0;
    logic [W-1:0]   m_data = '0;
    logic [IDW-1:0] m_id   = '0;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (v[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_ptr  <= 0;
            m_cyc  <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_busy) begin
                if (m_cyc >= m_acc + 2 && res_ready) m_busy <= 1'b0;
            end else if (|req_valid) begin
                int g;
                g = pick(req_valid, m_ptr);
                m_busy <= 1'b1;
                m_acc  <= m_cyc;
                m_id   <= IDW'(g);
                m_data <= req_a[g*W +: W] >> req_b[g*RS +: RS];
`ifdef DRS_ARB_RR_EN
                m_ptr  <= (g + 1) % N;
`endif
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        bit           exp_v;
        exp_v   = rst_n && m_busy && (m_cyc >= m_acc + 2);
        exp_rdy = '0;
        if (rst_n && !m_busy && |req_valid) exp_rdy = N'(1) << pick(req_valid, m_ptr);
        chk("cyc_req_ready", req_ready, exp_rdy);
        chk("cyc_res_valid", res_valid, exp_v);
        if (exp_v) begin
            chk("cyc_res_data", res_data, m_data);
            chk("cyc_res_id", res_id, m_id);
        end
    end

    int done_ids[$];
    always @(posedge clk) if (rst_n && res_valid && res_ready) done_ids.push_back(int'(res_id));

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [RS-1:0] b);
        req_valid[i]         = 1'b1;
        req_a[i*W +: W]      = a;
        req_b[i*RS +: RS]    = b;
    endtask

    task automatic wait_res(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk(name, ok, 1);
    endtask

    task automatic run_one(input string name, input int i, input logic [W-1:0] a,
                           input logic [RS-1:0] b, input logic [W-1:0] exp);
        set_req(i, a, b);
        step();
        req_valid = '0;
        wait_res({name, "_timeout"});
        chk(name, res_data, exp);
        step();
    endtask

    initial begin
        int cont_exp[5];
        int n3;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        #12;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_res_data", res_data, 0);
        chk("reset_res_id", res_id, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // single request, latency 2
        set_req(2, 32'hF000_0000, 5'd4);
        #1 chk("single_req_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        chk("single_t1_no_valid", res_valid, 0);
        step();
        chk("single_t2_valid", res_valid, 1);
        chk("single_t2_data", res_data, 32'h0F00_0000);
        chk("single_t2_id", res_id, 2);
        chk("model_single_data", m_data, 32'h0F00_0000);
        step();
        chk("single_t3_idle", res_valid, 0);

        // shift edges
        run_one("edge_b0", 0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
        run_one("edge_b31", 0, 32'h8000_0000, 5'd31, 32'h0000_0001);
        run_one("edge_no_sext", 0, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001);

        // backpressure, with req 3 waiting behind it
        res_ready = 1'b0;
        set_req(1, 32'h1234_5678, 5'd8);
        step();
        req_valid = '0;
        set_req(3, 32'hCAFE_F00D, 5'd16);
        wait_res("bp_timeout");
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 32'h0012_3456);
            chk("bp_id", res_id, 1);
            chk("bp_req_ready", req_ready, 0);
            step();
        end
        res_ready = 1'b1;
        step();
        chk("bp_release_idle", res_valid, 0);
        chk("bp_release_grant3", req_ready, 4'b1000);
        step();
        req_valid = '0;
        wait_res("bp3_timeout");
        chk("bp3_data", res_data, 32'h0000_CAFE);
        chk("bp3_id", res_id, 3);
        step();
        step();

        // contention
        done_ids.delete();
        for (int i = 0; i < N; i++) set_req(i, 32'hF0F0_0000 + i, 5'(i));
        for (int k = 0; k < 40 && done_ids.size() < 5; k++) step();
        req_valid = '0;
        chk("cont_count", done_ids.size(), 5);
`ifdef DRS_ARB_RR_EN
        cont_exp = '{0, 1, 2, 3, 0};
`else
        cont_exp = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 5; i++) begin
            if (i < done_ids.size()) chk($sformatf("cont_id%0d", i), done_ids[i], cont_exp[i]);
        end
        step();
        step();

        // withdrawal: req 3 valid for one cycle during SHIFT
        done_ids.delete();
        set_req(0, 32'h0000_FF00, 5'd8);
        step();
        req_valid = '0;
        set_req(3, 32'hAAAA_AAAA, 5'd1);
        step();
        req_valid = '0;
        wait_res("wd_timeout");
        step();
        repeat (4) step();
        chk("wd_count", done_ids.size(), 1);
        n3 = 0;
        foreach (done_ids[i]) if (done_ids[i] == 3) n3++;
        chk("wd_no_id3", n3, 0);
        if (done_ids.size() > 0) chk("wd_id0", done_ids[0], 0);

        // reset mid-SHIFT with req 1 in flight; req 2 held through reset
        done_ids.delete();
        set_req(1, 32'h1111_0000, 5'd4);
        step();
        req_valid = '0;
        set_req(2, 32'h2222_0000, 5'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", res_valid, 0);
        chk("rst_mid_ready", req_ready, 0);
        chk("rst_mid_data", res_data, 0);
        repeat (2) step();
        req_valid = '0;
        rst_n = 1'b1;
        repeat (6) step();
        chk("rst_no_result", done_ids.size(), 0);
        chk("rst_after_valid", res_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
